// File: rtl/arith_pkg.sv
// Shared arithmetic-block types: controller states for the serial power-of-two multiplier.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } mul_pow2_state_t;

endpackage

// File: rtl/signed_shl1_ovf.sv
// One-bit arithmetic left shift with a per-step signed-overflow flag.
module signed_shl1_ovf #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] y,
  output logic         step_ovf
);

  assign y = {x[N-2:0], 1'b0};
  // The sign bit is about to change, so this step leaves the signed range.
  assign step_ovf = x[N-1] ^ x[N-2];

endmodule

// File: rtl/signed_mul_pow2_serial.sv
// Serial signed a*2^s: one shift per clock, sticky overflow, optional clamping.
module signed_mul_pow2_serial
  import arith_pkg::*;
#(
  parameter int N   = 8,
  parameter int SW  = 3,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] s,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  res,
  output logic          ovf,
  output logic [1:0]    fsm_state
);

  // Handshake: a transfer happens on an edge where valid and ready are both 1;
  // valid never depends on ready, and payload is held stable while valid && !ready.

  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  mul_pow2_state_t state, next_state;
  logic [N-1:0]    acc;
  logic [SW-1:0]   cnt;
  logic            sgn;
  logic            ovf_r;
  logic [N-1:0]    acc_shl;
  logic            step_ovf;

  signed_shl1_ovf #(.N(N)) u_shl (
    .x        (acc),
    .y        (acc_shl),
    .step_ovf (step_ovf)
  );

  always_comb begin
    next_state = state;
    up_ready   = 1'b0;
    down_valid = 1'b0;
    case (state)
      IDLE: begin
        up_ready = 1'b1;
        if (up_valid) next_state = (s != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt == SW'(1)) next_state = DONE;
      end
      DONE: begin
        down_valid = 1'b1;
        if (down_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (up_valid) begin
            acc   <= a;
            cnt   <= s;
            sgn   <= a[N-1];
            ovf_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (step_ovf) ovf_r <= 1'b1;
          acc <= acc_shl;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Clamp direction follows the operand sign, since acc may have flipped sign.
  always_comb begin
    res = acc;
    if ((SAT != 0) && ovf_r) res = sgn ? MIN_NEG : MAX_POS;
  end

  assign ovf       = (state == DONE) && ovf_r;
  assign fsm_state = state;

endmodule

// File: tb/tb_signed_mul_pow2_serial.sv
// Randomised and directed bench for signed_mul_pow2_serial, saturating and wrapping builds.
module tb_signed_mul_pow2_serial;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic [N-1:0]  a;
  logic [SW-1:0] s;
  logic          down_ready;

  logic          up_ready, down_valid, ovf;
  logic [N-1:0]  res;
  logic [1:0]    fsm_state;
  logic          up_ready_w, down_valid_w, ovf_w;
  logic [N-1:0]  res_w;
  logic [1:0]    fsm_state_w;

  signed_mul_pow2_serial #(.N(N), .SW(SW), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready), .a(a), .s(s),
    .down_valid(down_valid), .down_ready(down_ready), .res(res), .ovf(ovf),
    .fsm_state(fsm_state)
  );

  signed_mul_pow2_serial #(.N(N), .SW(SW), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready_w), .a(a), .s(s),
    .down_valid(down_valid_w), .down_ready(down_ready), .res(res_w), .ovf(ovf_w),
    .fsm_state(fsm_state_w)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int last_accept = -100;
  int last_s      = 0;

  // scoreboard entry: {ovf, res_sat, res_wrap}
  logic [2*N:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: true integer product, then fit / clamp / truncate.
  function automatic logic [2*N:0] model(input logic [N-1:0] av, input int sv);
    int p;
    logic [N-1:0] wrap, sat;
    logic o;
    p    = $signed(av) * (1 << sv);
    o    = (p > 127) || (p < -128);
    wrap = p[N-1:0];
    sat  = o ? (av[N-1] ? 8'h80 : 8'h7F) : wrap;
    return {o, sat, wrap};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one operand through accept, shift, optional backpressure, handoff
  task automatic send(input logic [N-1:0] av, input logic [SW-1:0] sv, input int hold, input bit b2b);
    int n;
    logic [2*N:0] e;
    up_valid = 1'b1;
    a = av;
    s = sv;
    n = 0;
    while (!up_ready && n < 50) begin step(); n++; end
    if (!up_ready) begin
      check("accept_timeout", 0, 1);
      up_valid = 1'b0;
      return;
    end
    if (b2b) check("interval", cyc - last_accept, last_s + 2);
    last_accept = cyc;
    last_s      = int'(sv);
    exp_q.push_back(model(av, int'(sv)));
    step();
    up_valid = 1'b0;
    a = N'($urandom);
    s = SW'($urandom);
    n = 1;
    while (!down_valid && n < 20) begin step(); n++; end
    if (!down_valid) begin
      check("result_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    check("latency", n, int'(sv) + 1);
    e = exp_q.pop_front();
    check("res_sat", res, e[2*N-1:N]);
    check("ovf_sat", ovf, e[2*N]);
    check("res_wrap", res_w, e[N-1:0]);
    check("ovf_wrap", ovf_w, e[2*N]);
    check("up_ready_busy", up_ready, 0);
    if (hold > 0) begin
      down_ready = 1'b0;
      repeat (hold) begin
        step();
        check("hold_valid", down_valid, 1);
        check("hold_res", res, e[2*N-1:N]);
        check("hold_ovf", ovf, e[2*N]);
        check("hold_up_ready", up_ready, 0);
      end
    end
    down_ready = 1'b1;
    step();
    check("released_valid", down_valid, 0);
    check("released_ovf", ovf, 0);
    check("released_up_ready", up_ready, 1);
  endtask

  initial begin
    int hold;
    int prev_hold;
    rst = 1'b1;
    up_valid = 1'b0;
    a = '0;
    s = '0;
    down_ready = 1'b1;
    step();
    step();
    check("rst_up_ready", up_ready, 1);
    check("rst_down_valid", down_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_res", res, 0);
    check("rst_res_wrap", res_w, 0);
    rst = 1'b0;
    step();

    // directed cases
    send(8'h05, 3'd3, 0, 0);
    send(8'hFB, 3'd3, 0, 1);
    send(8'h30, 3'd2, 0, 1);
    send(8'h90, 3'd1, 0, 1);
    send(8'h81, 3'd0, 0, 1);
    send(8'h81, 3'd0, 0, 1);
    send(8'hFF, 3'd7, 0, 1);
    send(8'h00, 3'd7, 0, 1);
    send(8'h05, 3'd7, 3, 1);

    // abort mid-shift
    up_valid = 1'b1;
    a = 8'h05;
    s = 3'd7;
    step();
    up_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_down_valid", down_valid, 0);
    check("abort_up_ready", up_ready, 1);
    check("abort_res", res, 0);
    check("abort_ovf", ovf, 0);
    repeat (8) begin
      step();
      check("abort_no_result", down_valid, 0);
    end
    send(8'hF0, 3'd3, 0, 0);

    // randomised traffic with occasional backpressure
    prev_hold = 0;
    for (int i = 0; i < 150; i++) begin
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      send(N'($urandom), SW'($urandom_range(0, 7)), hold, prev_hold == 0);
      prev_hold = hold;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
